// File: rtl/dmem_bus_bridge_pkg.sv
// rtl/dmem_bus_bridge_pkg.sv - shared word widths, enable constants and request record for the data-memory bus bridge
package dmem_bus_bridge_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int SEL_W  = 4;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [WORD_W-1:0] ZERO_WORD = '0;

    // Request fields captured from the memory-access stage and replayed on the bus.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  sel;
        logic [WORD_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - saturating wait counter that flags when a bus access has waited too long
//
// Ports:
//   clk     in  rising-edge clock
//   rst     in  synchronous active-high reset
//   clear   in  force the count to zero (held while no access is outstanding)
//   enable  in  count one waited cycle
//   expired out count has reached TIMEOUT_CYCLES-1
module bus_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Stops at LIMIT so the count can never wrap back into range.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - bridges the pipeline memory-access stage onto a request/ack data bus with stall and timeout
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_ce_i/we_i/addr_i/sel_i/data_i   access request from the memory-access stage
//   mem_data_o                   read data returned to the stage (held until next capture)
//   stallreq_o                   stall request while an access is outstanding
//   bus_req_o/we_o/addr_o/sel_o/wdata_o external bus request, valid only while BUSY
//   bus_ack_i, bus_rdata_i       bus completion and read data
//   err_o                        one-cycle pulse when an access is abandoned
module dmem_bus_bridge
    import dmem_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    input  logic [WORD_W-1:0] mem_data_i,
    output logic [WORD_W-1:0] mem_data_o,
    output logic              stallreq_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [SEL_W-1:0]  bus_sel_o,
    output logic [WORD_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [WORD_W-1:0] bus_rdata_i,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, next_state;
    bus_req_t          req_q;
    logic [WORD_W-1:0] data_q;
    logic              busy;
    logic              start;
    logic              capture;
    logic [WORD_W-1:0] capture_word;
    logic              expired;

    assign busy = (state == ST_BUSY);

    // Timer is held clear outside BUSY, so every access starts counting from zero.
    bus_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy && !bus_ack_i),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        stallreq_o   = 1'b0;
        err_o        = 1'b0;
        start        = 1'b0;
        capture      = 1'b0;
        capture_word = ZERO_WORD;
        case (state)
            ST_IDLE: begin
                if (mem_ce_i == CHIP_ENABLE) begin
                    stallreq_o = 1'b1;
                    start      = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stallreq_o = 1'b1;
                // Ack takes priority over a timeout landing in the same cycle.
                if (bus_ack_i) begin
                    capture      = 1'b1;
                    capture_word = (req_q.we == WRITE_ENABLE) ? ZERO_WORD : bus_rdata_i;
                    next_state   = ST_DONE;
                end else if (expired) begin
                    capture    = 1'b1;
                    err_o      = 1'b1;
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // Always return to IDLE so a held mem_ce_i is seen as a new request.
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        // The stage must never be stalled, nor an error flagged, while reset is held.
        if (rst) begin
            stallreq_o = 1'b0;
            err_o      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (start) begin
            req_q.we    <= (mem_we_i == WRITE_ENABLE);
            req_q.addr  <= mem_addr_i;
            req_q.sel   <= mem_sel_i;
            req_q.wdata <= mem_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= ZERO_WORD;
        end else if (capture) begin
            data_q <= capture_word;
        end
    end

    assign mem_data_o  = data_q;
    assign bus_req_o   = busy;
    assign bus_we_o    = busy && req_q.we;
    assign bus_addr_o  = busy ? req_q.addr  : '0;
    assign bus_sel_o   = busy ? req_q.sel   : '0;
    assign bus_wdata_o = busy ? req_q.wdata : ZERO_WORD;

endmodule

// File: doc/dmem_bus_bridge.md
DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum BUSY cycles before an access is abandoned.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port mem_ce_i  in  1  access request from memory-access stage (ChipEnable=1).
REQ-005 SHALL have port mem_we_i  in  1  1=write, 0=read.
REQ-006 SHALL have port mem_addr_i  in  32  byte address, passed through unmodified.
REQ-007 SHALL have port mem_sel_i  in  4  byte lanes; bit3=bits[31:24] (big-endian lane order).
REQ-008 SHALL have port mem_data_i  in  32  write data.
REQ-009 SHALL have port mem_data_o  out  32  read data returned to memory-access stage.
REQ-010 SHALL have port stallreq_o  out  1  pipeline stall request to stall controller.
REQ-011 SHALL have ports bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_sel_o out 4, bus_wdata_o out 32: external data-bus request.
REQ-012 SHALL have ports bus_ack_i in 1, bus_rdata_i in 32: bus completion and read data.
REQ-013 SHALL have port err_o  out  1  one-cycle pulse on timeout.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 IDLE: mem_ce_i=0 -> stay, stallreq_o=0; mem_ce_i=1 -> stallreq_o=1 combinationally, latch we/addr/sel/wdata, next BUSY.
REQ-016 BUSY: bus_req_o=1 with latched fields; stallreq_o=1; bus fields stable until ack.
REQ-017 BUSY and bus_ack_i=1 -> capture bus_rdata_i (reads; writes capture 0), bus_req_o low next cycle, next DONE.
REQ-018 DONE: stallreq_o=0 for exactly one cycle; mem_data_o=captured data; bus_req_o=0; next IDLE unconditionally (no reissue of held request).
REQ-019 mem_data_o SHALL hold captured data in all states until the next capture.
REQ-020 Minimum latency: request in cycle N, ack in N+1 -> DONE in N+2; stall covers N..N+1.
REQ-021 Wait counter SHALL clear on BUSY entry and increment per BUSY cycle without ack; at TIMEOUT_CYCLES-1 without ack -> DONE, data=0, err_o=1 for that transition cycle.
REQ-022 Ack and timeout in the same cycle -> ack wins, err_o=0.
REQ-023 bus_ack_i outside BUSY SHALL be ignored.
REQ-024 mem_sel_i=0000 with mem_ce_i=1 SHALL still perform the bus cycle (sel passed through).
REQ-025 Counter SHALL be $clog2(TIMEOUT_CYCLES)+1 bits, never wrap.

Reset
REQ-026 rst=1 at any edge, including mid-BUSY, SHALL force IDLE; bus_req_o=0, bus_we_o=0, bus_addr_o=0, bus_sel_o=0000, bus_wdata_o=0, mem_data_o=0, err_o=0, counter=0.
REQ-027 During rst, stallreq_o SHALL be 0 regardless of mem_ce_i.

Structure
REQ-028 Word widths, ChipEnable/WriteEnable and ZeroWord constants SHALL come from the shared defines file; FSM state encodings local.
REQ-029 Wait counter SHALL be sub-module bus_wait_timer (clear, enable, expired output).

Verification
REQ-030 Read, addr=0x0000_0010, sel=1111, ack one cycle later with rdata=0xDEADBEEF -> stall 2 cycles, DONE mem_data_o=0xDEADBEEF, err_o=0.
REQ-031 Write, addr=0x24, sel=0011, wdata=0x1234_5678, ack after 5 cycles -> bus fields stable 5 cycles, bus_we_o=1, one DONE cycle.
REQ-032 Read with no ack, TIMEOUT_CYCLES=16 -> DONE after 16 BUSY cycles, mem_data_o=0, err_o single pulse.
REQ-033 rst asserted in 3rd BUSY cycle -> next cycle IDLE, bus_req_o=0, stallreq_o=0.
REQ-034 Back-to-back requests (mem_ce_i held high) -> exactly one bus cycle per request, DONE separates them, no duplicate bus_req.
REQ-035 Ack on the 16th BUSY cycle -> data captured, err_o=0.
